// File: rtl/branch_pc_sequencer_if.sv
// Bus bundle between the PC sequencer, instruction memory, the branch evaluator
// and whoever observes the architectural PC and branch statistics.
interface branch_pc_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             Run;
  logic             InstrReq;
  logic [31:0]      InstrAddr;
  logic             InstrValid;
  logic [31:0]      Instr;
  logic             BranchCTL;
  logic [5:0]       BrOpCode;
  logic             BranchOut;
  logic [31:0]      PC;
  logic             InstrDone;
  logic [CNT_W-1:0] BranchCount;
  logic [CNT_W-1:0] TakenCount;

  modport master (
    input  Run, InstrValid, Instr, BranchOut,
    output InstrReq, InstrAddr, BranchCTL, BrOpCode, PC, InstrDone,
           BranchCount, TakenCount
  );

  modport slave (
    output Run, InstrValid, Instr, BranchOut,
    input  InstrReq, InstrAddr, BranchCTL, BrOpCode, PC, InstrDone,
           BranchCount, TakenCount
  );
endinterface

// File: rtl/branch_pc_sequencer.sv
// Multicycle PC sequencer: fetch, decode, hand branches to the external evaluator,
// then commit PC+4 or the branch target and keep saturating branch statistics.
module branch_pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_pc_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_RESOLVE,
    S_UPDATE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_pc;
  logic [5:0]       r_opcode;
  logic [15:0]      r_offset;
  logic             r_taken;
  logic [CNT_W-1:0] r_branchCount;
  logic [CNT_W-1:0] r_takenCount;

  logic             w_isBranch;
  logic             w_accept;
  logic [31:0]      w_offsetBytes;
  logic [31:0]      w_seqPc;
  logic [31:0]      w_targetPc;
  logic             w_unused;

  // BEQ/BNE/BLT/BLE all share the 1000xx opcode prefix.
  assign w_isBranch    = (r_opcode[5:2] == 4'b1000);
  assign w_accept      = (r_state == S_FETCH) && bus.InstrValid;
  assign w_offsetBytes = {{14{r_offset[15]}}, r_offset, 2'b00};
  assign w_seqPc       = r_pc + 32'd4;
  assign w_targetPc    = w_seqPc + w_offsetBytes;
  assign w_unused      = &{1'b0, bus.Instr[25:16]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.Run) w_next = S_FETCH;
      S_FETCH:   if (bus.InstrValid) w_next = S_DECODE;
      S_DECODE:  w_next = w_isBranch ? S_EXEC : S_UPDATE;
      S_EXEC:    w_next = S_RESOLVE;
      S_RESOLVE: w_next = S_UPDATE;
      S_UPDATE:  w_next = bus.Run ? S_FETCH : S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_opcode      <= '0;
      r_offset      <= '0;
      r_taken       <= 1'b0;
      r_branchCount <= '0;
      r_takenCount  <= '0;
    end else begin
      if (w_accept) begin
        r_opcode <= bus.Instr[31:26];
        r_offset <= bus.Instr[15:0];
        r_taken  <= 1'b0;
      end
      if (r_state == S_RESOLVE) begin
        r_taken <= bus.BranchOut;
      end
      if (r_state == S_UPDATE) begin
        r_pc <= (w_isBranch && r_taken) ? w_targetPc : w_seqPc;
        // Statistics stick at all-ones rather than wrapping.
        if (w_isBranch) begin
          if (r_branchCount != {CNT_W{1'b1}}) begin
            r_branchCount <= r_branchCount + CNT_W'(1);
          end
          if (r_taken && (r_takenCount != {CNT_W{1'b1}})) begin
            r_takenCount <= r_takenCount + CNT_W'(1);
          end
        end
      end
    end
  end

  // Opcode stays on the evaluator bus from DECODE through UPDATE so it is
  // already stable when BranchCTL rises in EXEC.
  always_comb begin
    bus.InstrReq  = 1'b0;
    bus.BranchCTL = 1'b0;
    bus.InstrDone = 1'b0;
    bus.BrOpCode  = 6'b0;
    case (r_state)
      S_FETCH:   bus.InstrReq = 1'b1;
      S_DECODE:  bus.BrOpCode = r_opcode;
      S_EXEC: begin
        bus.BranchCTL = 1'b1;
        bus.BrOpCode  = r_opcode;
      end
      S_RESOLVE: begin
        bus.BranchCTL = 1'b1;
        bus.BrOpCode  = r_opcode;
      end
      S_UPDATE: begin
        bus.InstrDone = 1'b1;
        bus.BrOpCode  = r_opcode;
      end
      default: ;
    endcase
  end

  assign bus.InstrAddr   = r_pc;
  assign bus.PC          = r_pc;
  assign bus.BranchCount = r_branchCount;
  assign bus.TakenCount  = r_takenCount;

endmodule
